// File: rtl/rf_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
package rf_mp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Low bit index of element k in a flattened vector of w-bit elements.
  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/rf_mp_if.sv
// Decode-stage register file bus: read ports, two write ports, claim and clear.
interface rf_mp_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRP  = 2
);

  logic [NRP*AW-1:0]   i_raddr;
  logic [NRP*XLEN-1:0] o_rdata;
  logic [NRP-1:0]      o_rbusy;
  logic                i_wa_en;
  logic [AW-1:0]       i_wa_addr;
  logic [XLEN-1:0]     i_wa_data;
  logic                i_wb_en;
  logic [AW-1:0]       i_wb_addr;
  logic [XLEN-1:0]     i_wb_data;
  logic                i_claim_en;
  logic [AW-1:0]       i_claim_addr;
  logic                i_clr;
  logic                o_ready;

  modport master (
    output i_raddr, i_wa_en, i_wa_addr, i_wa_data,
    output i_wb_en, i_wb_addr, i_wb_data,
    output i_claim_en, i_claim_addr, i_clr,
    input  o_rdata, o_rbusy, o_ready
  );

  modport slave (
    input  i_raddr, i_wa_en, i_wa_addr, i_wa_data,
    input  i_wb_en, i_wb_addr, i_wb_data,
    input  i_claim_en, i_claim_addr, i_clr,
    output o_rdata, o_rbusy, o_ready
  );

endinterface

// File: rtl/rf_mp_rport.sv
// One combinational read port: zero/clear/bypass data mux and busy override.
module rf_mp_rport #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned AW        = 5,
  parameter bit          BYPASS_EN = 1'b1,
  parameter bit          ZERO_REG  = 1'b1
) (
  input  logic [AW-1:0]   raddr,
  input  logic [XLEN-1:0] stored_data,
  input  logic            stored_busy,
  input  logic            clearing,
  input  logic            wa_en,
  input  logic [AW-1:0]   wa_addr,
  input  logic [XLEN-1:0] wa_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            claim_en,
  input  logic [AW-1:0]   claim_addr,
  output logic [XLEN-1:0] rdata_c,
  output logic            rbusy_c
);

  logic hit_a;
  logic hit_b;
  logic hit_claim;

  // Priority mux for read data and the bypass-aware busy flag.
  always_comb begin
    hit_a     = BYPASS_EN && wa_en && (wa_addr == raddr);
    hit_b     = BYPASS_EN && wb_en && (wb_addr == raddr);
    hit_claim = claim_en && (claim_addr == raddr);
    rdata_c   = stored_data;
    rbusy_c   = stored_busy;
    if (ZERO_REG && (raddr == '0)) begin
      rdata_c = '0;
    end else if (clearing) begin
      rdata_c = '0;
    end else if (hit_a) begin
      rdata_c = wa_data;
    end else if (hit_b) begin
      rdata_c = wb_data;
    end
    if ((hit_a || hit_b) && !hit_claim) begin
      rbusy_c = 1'b0;
    end
  end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file with dual write ports, busy scoreboard and sequenced clear.
module rf_mp
  import rf_mp_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned NRP       = 2,
  parameter bit          BYPASS_EN = 1'b1,
  parameter bit          ZERO_REG  = 1'b1
) (
  input logic   i_clk,
  input logic   i_rst_n,
  rf_mp_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e          state_q;
  state_e          state_d;
  logic [AW-1:0]   idx_q;
  logic [AW-1:0]   idx_d;
  logic            ready_c;
  logic            clr_start_c;
  logic            wa_ok_c;
  logic            wb_ok_c;
  logic            claim_ok_c;
  logic [XLEN-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q;

  // Qualified write/claim strobes: only in IDLE, never alongside a clear request.
  always_comb begin
    clr_start_c = (state_q == IDLE) && bus.i_clr;
    wa_ok_c     = (state_q == IDLE) && !bus.i_clr && bus.i_wa_en &&
                  !(ZERO_REG && (bus.i_wa_addr == '0));
    wb_ok_c     = (state_q == IDLE) && !bus.i_clr && bus.i_wb_en &&
                  !(ZERO_REG && (bus.i_wb_addr == '0));
    claim_ok_c  = (state_q == IDLE) && !bus.i_clr && bus.i_claim_en &&
                  !(ZERO_REG && (bus.i_claim_addr == '0));
  end

  // Clear sequencer next-state and ready decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_c = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (bus.i_clr) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and clear index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Register storage: clear walks one entry per cycle; port A written last so it wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (state_q == CLEAR) begin
      regs_q[idx_q] <= '0;
    end else begin
      if (wb_ok_c) regs_q[bus.i_wb_addr] <= bus.i_wb_data;
      if (wa_ok_c) regs_q[bus.i_wa_addr] <= bus.i_wa_data;
    end
  end

  // Busy scoreboard: writes release, claim applied last so it wins on collision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q <= '0;
    end else if (clr_start_c) begin
      busy_q <= '0;
    end else begin
      if (wb_ok_c)    busy_q[bus.i_wb_addr]    <= 1'b0;
      if (wa_ok_c)    busy_q[bus.i_wa_addr]    <= 1'b0;
      if (claim_ok_c) busy_q[bus.i_claim_addr] <= 1'b1;
    end
  end

  assign bus.o_ready = ready_c;

  // Independent read ports.
  for (genvar k = 0; k < int'(NRP); k++) begin : g_rport
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;

    assign ra = bus.i_raddr[slice_lo(32'(k), AW) +: AW];

    rf_mp_rport #(
      .XLEN      (XLEN),
      .AW        (AW),
      .BYPASS_EN (BYPASS_EN),
      .ZERO_REG  (ZERO_REG)
    ) u_rport (
      .raddr       (ra),
      .stored_data (regs_q[ra]),
      .stored_busy (busy_q[ra]),
      .clearing    (state_q == CLEAR),
      .wa_en       (wa_ok_c),
      .wa_addr     (bus.i_wa_addr),
      .wa_data     (bus.i_wa_data),
      .wb_en       (wb_ok_c),
      .wb_addr     (bus.i_wb_addr),
      .wb_data     (bus.i_wb_data),
      .claim_en    (claim_ok_c),
      .claim_addr  (bus.i_claim_addr),
      .rdata_c     (rd),
      .rbusy_c     (rb)
    );

    assign bus.o_rdata[slice_lo(32'(k), XLEN) +: XLEN] = rd;
    assign bus.o_rbusy[k] = rb;
  end

endmodule

// File: tb/tb_rf_mp.sv
// Directed bench for rf_mp: one bypassing instance and one non-bypassing instance, same stimulus.
module tb_rf_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRP   = 2;

  logic clk;
  logic rst_n;

  logic [NRP*AW-1:0] raddr;
  logic              wa_en, wb_en, claim_en, clr;
  logic [AW-1:0]     wa_addr, wb_addr, claim_addr;
  logic [XLEN-1:0]   wa_data, wb_data;

  int n_cmp;
  int n_err;
  int cnt;

  rf_mp_if #(.XLEN(XLEN), .AW(AW), .NRP(NRP)) bus_b ();
  rf_mp_if #(.XLEN(XLEN), .AW(AW), .NRP(NRP)) bus_n ();

  assign bus_b.i_raddr = raddr;      assign bus_n.i_raddr = raddr;
  assign bus_b.i_wa_en = wa_en;      assign bus_n.i_wa_en = wa_en;
  assign bus_b.i_wa_addr = wa_addr;  assign bus_n.i_wa_addr = wa_addr;
  assign bus_b.i_wa_data = wa_data;  assign bus_n.i_wa_data = wa_data;
  assign bus_b.i_wb_en = wb_en;      assign bus_n.i_wb_en = wb_en;
  assign bus_b.i_wb_addr = wb_addr;  assign bus_n.i_wb_addr = wb_addr;
  assign bus_b.i_wb_data = wb_data;  assign bus_n.i_wb_data = wb_data;
  assign bus_b.i_claim_en = claim_en;     assign bus_n.i_claim_en = claim_en;
  assign bus_b.i_claim_addr = claim_addr; assign bus_n.i_claim_addr = claim_addr;
  assign bus_b.i_clr = clr;          assign bus_n.i_clr = clr;

  rf_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRP(NRP), .BYPASS_EN(1'b1), .ZERO_REG(1'b1)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_b)
  );

  rf_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRP(NRP), .BYPASS_EN(1'b0), .ZERO_REG(1'b1)) dut_nb (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    raddr = {AW'(a1), AW'(a0)};
  endtask

  task automatic quiet();
    wa_en = 1'b0; wb_en = 1'b0; claim_en = 1'b0; clr = 1'b0;
  endtask

  task automatic wr_a(input int a, input logic [31:0] d);
    wa_en = 1'b1; wa_addr = AW'(a); wa_data = d;
  endtask

  task automatic wr_b(input int a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = AW'(a); wb_data = d;
  endtask

  task automatic claim(input int a);
    claim_en = 1'b1; claim_addr = AW'(a);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    quiet();
    wa_addr = '0; wa_data = '0; wb_addr = '0; wb_data = '0; claim_addr = '0;
    set_rd(5, 0);
    #3;
    chk("rst_ready", 32'(bus_b.o_ready), 32'd1);
    chk("rst_rd_x5", bus_b.o_rdata[31:0], 32'd0);
    chk("rst_busy", 32'(bus_b.o_rbusy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Port A write then read back; x0 always zero
    wr_a(5, 32'hDEADBEEF);
    tick();
    quiet();
    set_rd(5, 0); #1;
    chk("wa_x5", bus_b.o_rdata[31:0], 32'hDEADBEEF);
    chk("x0_p1", bus_b.o_rdata[63:32], 32'd0);
    set_rd(0, 0); #1;
    chk("x0_p0", bus_b.o_rdata[31:0], 32'd0);
    wr_a(0, 32'hFFFF_FFFF); #1;
    chk("x0_wr_bypass", bus_b.o_rdata[31:0], 32'd0);
    tick();
    quiet(); #1;
    chk("x0_after_wr", bus_b.o_rdata[63:32], 32'd0);

    // Same-cycle bypass vs. registered-only read
    wr_a(7, 32'h1234);
    set_rd(0, 7); #1;
    chk("byp_on", bus_b.o_rdata[63:32], 32'h1234);
    chk("byp_off_old", bus_n.o_rdata[63:32], 32'h0);
    tick();
    quiet(); #1;
    chk("byp_off_next", bus_n.o_rdata[63:32], 32'h1234);

    // A/B collision: A wins; B alone
    wr_a(3, 32'hAAAA);
    wr_b(3, 32'h5555);
    tick();
    quiet();
    set_rd(3, 3); #1;
    chk("ab_collide", bus_b.o_rdata[31:0], 32'hAAAA);
    chk("ab_collide_nb", bus_n.o_rdata[63:32], 32'hAAAA);
    wr_b(4, 32'h77);
    tick();
    quiet();
    set_rd(4, 3); #1;
    chk("wb_x4", bus_b.o_rdata[31:0], 32'h77);

    // Scoreboard
    claim(9);
    tick();
    quiet();
    set_rd(9, 0); #1;
    chk("claim_x9", 32'(bus_b.o_rbusy[0]), 32'd1);
    wr_b(9, 32'h99);
    claim(9); #1;
    chk("claim_wr_comb", 32'(bus_b.o_rbusy[0]), 32'd1);
    tick();
    quiet(); #1;
    chk("claim_wins", 32'(bus_b.o_rbusy[0]), 32'd1);
    wr_b(9, 32'h98); #1;
    chk("wr_byp_busy", 32'(bus_b.o_rbusy[0]), 32'd0);
    chk("wr_nb_busy", 32'(bus_n.o_rbusy[0]), 32'd1);
    tick();
    quiet(); #1;
    chk("busy_rel", 32'(bus_b.o_rbusy[0]), 32'd0);
    chk("wb_x9", bus_b.o_rdata[31:0], 32'h98);
    claim(0);
    tick();
    quiet();
    set_rd(0, 0); #1;
    chk("claim_x0", 32'(bus_b.o_rbusy), 32'd0);

    // Fill, then sequenced clear
    for (int i = 1; i < 32; i++) begin
      wr_a(i, 32'h100 + 32'(i));
      tick();
    end
    quiet();
    set_rd(31, 1); #1;
    chk("fill_x31", bus_b.o_rdata[31:0], 32'h11F);
    chk("fill_x1", bus_b.o_rdata[63:32], 32'h101);
    wr_a(2, 32'hBAD);
    claim(2);
    clr = 1'b1;
    tick();
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (bus_b.o_ready) break;
      cnt++;
      chk("clr_rd0", bus_b.o_rdata[31:0], 32'd0);
      chk("clr_rd1", bus_b.o_rdata[63:32], 32'd0);
      tick();
    end
    quiet();
    chk("clr_len", 32'(cnt), 32'd32);
    chk("clr_nb_ready", 32'(bus_n.o_ready), 32'd1);
    for (int a = 0; a < 32; a++) begin
      set_rd(a, a); #1;
      chk("post_clr_reg", bus_b.o_rdata[31:0], 32'd0);
    end
    set_rd(2, 2); #1;
    chk("post_clr_busy", 32'(bus_b.o_rbusy), 32'd0);

    // Reset during clear
    tick();
    wr_a(5, 32'h55);
    tick();
    wr_a(31, 32'h31);
    tick();
    quiet();
    set_rd(5, 31); #1;
    chk("pre_rst_x5", bus_b.o_rdata[31:0], 32'h55);
    chk("pre_rst_x31", bus_b.o_rdata[63:32], 32'h31);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    chk("mid_clr_ready", 32'(bus_b.o_ready), 32'd0);
    rst_n = 1'b0; #1;
    chk("abort_ready", 32'(bus_b.o_ready), 32'd1);
    chk("abort_x5", bus_b.o_rdata[31:0], 32'd0);
    chk("abort_x31", bus_b.o_rdata[63:32], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(bus_b.o_ready), 32'd1);
    wr_a(5, 32'h99);
    tick();
    quiet(); #1;
    chk("post_rst_wr", bus_b.o_rdata[31:0], 32'h99);
    chk("post_rst_x31", bus_b.o_rdata[63:32], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
